// File: rtl/rect_move_ctl_if.sv
// Control/position bundle between vga_timing, rect_move_ctl and the rectangle drawer.
interface rect_move_ctl_if;
   localparam int unsigned POS_W = 11;
   localparam int unsigned CNT_W = 8;

   logic             vblnk_in;
   logic             start;
   logic             stop;
   logic [POS_W-1:0] xpos;
   logic [POS_W-1:0] ypos;
   logic             running;
   logic             frame_tick;
   logic [CNT_W-1:0] bounce_cnt;

   // Timing/sequencing side: drives blanking and run/stop pulses, observes position.
   modport master (
      output vblnk_in, start, stop,
      input  xpos, ypos, running, frame_tick, bounce_cnt
   );

   // Controller side.
   modport slave (
      input  vblnk_in, start, stop,
      output xpos, ypos, running, frame_tick, bounce_cnt
   );
endinterface

// File: rtl/rect_move_ctl.sv
// Frame-synchronous bouncing-rectangle position controller; positions change only in vertical blank.
module rect_move_ctl #(
   parameter int unsigned H_ACTIVE = 1024,
   parameter int unsigned V_ACTIVE = 768,
   parameter int unsigned RECT_W   = 48,
   parameter int unsigned RECT_H   = 64,
   parameter int unsigned X_INIT   = 100,
   parameter int unsigned Y_INIT   = 100,
   parameter int unsigned STEP_X   = 2,
   parameter int unsigned STEP_Y   = 1
) (
   input  logic           pclk,
   input  logic           rst,
   rect_move_ctl_if.slave bus
);

   localparam int unsigned POS_W = 11;
   localparam int unsigned AW    = 12;
   localparam int unsigned CNT_W = 8;

   localparam logic [AW-1:0]    X_MAX   = AW'(H_ACTIVE - RECT_W);
   localparam logic [AW-1:0]    Y_MAX   = AW'(V_ACTIVE - RECT_H);
   localparam logic [AW-1:0]    STEP_XW = AW'(STEP_X);
   localparam logic [AW-1:0]    STEP_YW = AW'(STEP_Y);
   localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t           state;
   state_t           state_nxt;
   logic             vblnk_d;
   logic             frame_tick;
   logic             running;
   logic [POS_W-1:0] xpos;
   logic [POS_W-1:0] ypos;
   logic             dir_x_neg;
   logic             dir_y_neg;
   logic [CNT_W-1:0] bounce_cnt;

   logic             tick_c;
   logic             upd_c;
   logic [AW-1:0]    x_wide_c;
   logic [AW-1:0]    y_wide_c;
   logic [AW-1:0]    x_nxt_c;
   logic [AW-1:0]    y_nxt_c;
   logic             dir_x_nxt_c;
   logic             dir_y_nxt_c;
   logic             hit_x_c;
   logic             hit_y_c;

   assign tick_c   = bus.vblnk_in & ~vblnk_d;
   assign upd_c    = frame_tick & (state == RUN);
   assign x_wide_c = AW'(xpos);
   assign y_wide_c = AW'(ypos);

   // FSM state register.
   always_ff @(posedge pclk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // FSM next state: stop always wins over start.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start && !bus.stop) state_nxt = RUN;
         RUN:     if (bus.stop)               state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Horizontal step with clamp-and-reverse at the active-area edges.
   always_comb begin
      x_nxt_c     = x_wide_c;
      dir_x_nxt_c = dir_x_neg;
      hit_x_c     = 1'b0;
      if (!dir_x_neg) begin
         if (x_wide_c + STEP_XW >= X_MAX) begin
            x_nxt_c     = X_MAX;
            dir_x_nxt_c = 1'b1;
            hit_x_c     = 1'b1;
         end else begin
            x_nxt_c = x_wide_c + STEP_XW;
         end
      end else begin
         if (x_wide_c <= STEP_XW) begin
            x_nxt_c     = '0;
            dir_x_nxt_c = 1'b0;
            hit_x_c     = 1'b1;
         end else begin
            x_nxt_c = x_wide_c - STEP_XW;
         end
      end
   end

   // Vertical step with clamp-and-reverse at the active-area edges.
   always_comb begin
      y_nxt_c     = y_wide_c;
      dir_y_nxt_c = dir_y_neg;
      hit_y_c     = 1'b0;
      if (!dir_y_neg) begin
         if (y_wide_c + STEP_YW >= Y_MAX) begin
            y_nxt_c     = Y_MAX;
            dir_y_nxt_c = 1'b1;
            hit_y_c     = 1'b1;
         end else begin
            y_nxt_c = y_wide_c + STEP_YW;
         end
      end else begin
         if (y_wide_c <= STEP_YW) begin
            y_nxt_c     = '0;
            dir_y_nxt_c = 1'b0;
            hit_y_c     = 1'b1;
         end else begin
            y_nxt_c = y_wide_c - STEP_YW;
         end
      end
   end

   // Blank-edge detect, run flag and position/bounce registers.
   always_ff @(posedge pclk) begin
      if (rst) begin
         vblnk_d    <= 1'b1;
         frame_tick <= 1'b0;
         running    <= 1'b0;
         xpos       <= POS_W'(X_INIT);
         ypos       <= POS_W'(Y_INIT);
         dir_x_neg  <= 1'b0;
         dir_y_neg  <= 1'b0;
         bounce_cnt <= '0;
      end else begin
         vblnk_d    <= bus.vblnk_in;
         frame_tick <= tick_c;
         running    <= (state_nxt == RUN);
         if (upd_c) begin
            xpos      <= POS_W'(x_nxt_c);
            ypos      <= POS_W'(y_nxt_c);
            dir_x_neg <= dir_x_nxt_c;
            dir_y_neg <= dir_y_nxt_c;
            if ((hit_x_c || hit_y_c) && (bounce_cnt != CNT_SAT))
               bounce_cnt <= bounce_cnt + CNT_W'(1);
         end
      end
   end

   assign bus.xpos       = xpos;
   assign bus.ypos       = ypos;
   assign bus.running    = running;
   assign bus.frame_tick = frame_tick;
   assign bus.bounce_cnt = bounce_cnt;

endmodule

// File: tb/tb_rect_move_ctl.sv
// Directed bench for rect_move_ctl: idle frames, motion/latency, edge and corner bounce,
// run/stop sequencing and mid-frame reset.
module tb_rect_move_ctl;

   logic pclk;
   logic rst;
   int   n_chk;
   int   n_fail;
   int   tick_cnt;
   int   tick0;

   rect_move_ctl_if ifa ();
   rect_move_ctl_if ifb ();
   rect_move_ctl_if ifc ();

   // Edge/corner instances share the stimulus of the main instance.
   assign ifb.vblnk_in = ifa.vblnk_in;
   assign ifb.start    = ifa.start;
   assign ifb.stop     = ifa.stop;
   assign ifc.vblnk_in = ifa.vblnk_in;
   assign ifc.start    = ifa.start;
   assign ifc.stop     = ifa.stop;

   rect_move_ctl dut_a (.pclk(pclk), .rst(rst), .bus(ifa.slave));
   rect_move_ctl #(.X_INIT(975), .Y_INIT(703)) dut_b (.pclk(pclk), .rst(rst), .bus(ifb.slave));
   rect_move_ctl #(.X_INIT(975), .Y_INIT(100)) dut_c (.pclk(pclk), .rst(rst), .bus(ifc.slave));

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   // Count frame_tick high cycles on the main instance.
   initial tick_cnt = 0;
   always @(negedge pclk) if (ifa.frame_tick === 1'b1) tick_cnt = tick_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (got !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   // Blank low for a while, then rise; returns in the cycle frame_tick is high.
   task automatic frame_begin();
      ifa.vblnk_in = 1'b0;
      repeat (3) step();
      ifa.vblnk_in = 1'b1;
      step();
      chk("tick_high", 32'(ifa.frame_tick), 1);
   endtask

   // One cycle later: tick gone and new positions visible.
   task automatic frame_end();
      step();
      chk("tick_low", 32'(ifa.frame_tick), 0);
   endtask

   task automatic run_frame();
      frame_begin();
      frame_end();
      step();
      step();
   endtask

   task automatic pulse(input logic s, input logic p);
      ifa.start = s;
      ifa.stop  = p;
      step();
      ifa.start = 1'b0;
      ifa.stop  = 1'b0;
   endtask

   initial begin
      n_chk        = 0;
      n_fail       = 0;
      rst          = 1'b1;
      ifa.vblnk_in = 1'b0;
      ifa.start    = 1'b0;
      ifa.stop     = 1'b0;

      // Reset state
      step();
      step();
      chk("rst_x", 32'(ifa.xpos), 100);
      chk("rst_y", 32'(ifa.ypos), 100);
      chk("rst_run", 32'(ifa.running), 0);
      chk("rst_tick", 32'(ifa.frame_tick), 0);
      chk("rst_bounce", 32'(ifa.bounce_cnt), 0);
      chk("rst_bx", 32'(ifb.xpos), 975);
      rst = 1'b0;
      step();

      // Idle frames: ticks but no motion
      tick0 = tick_cnt;
      repeat (3) run_frame();
      chk("idle_ticks", 32'(tick_cnt - tick0), 3);
      chk("idle_x", 32'(ifa.xpos), 100);
      chk("idle_y", 32'(ifa.ypos), 100);
      chk("idle_run", 32'(ifa.running), 0);

      // Start and first frame with latency check
      pulse(1'b1, 1'b0);
      chk("start_run", 32'(ifa.running), 1);
      frame_begin();
      chk("lat_x_old", 32'(ifa.xpos), 100);
      chk("lat_y_old", 32'(ifa.ypos), 100);
      frame_end();
      chk("lat_x_new", 32'(ifa.xpos), 102);
      chk("lat_y_new", 32'(ifa.ypos), 101);
      chk("corner_x", 32'(ifb.xpos), 976);
      chk("corner_y", 32'(ifb.ypos), 704);
      chk("corner_bounce", 32'(ifb.bounce_cnt), 1);
      chk("edge_x", 32'(ifc.xpos), 976);
      chk("edge_y", 32'(ifc.ypos), 101);
      chk("edge_bounce", 32'(ifc.bounce_cnt), 1);
      step();
      step();

      // Second frame: direction reversed on the bounced axes
      run_frame();
      chk("corner_x2", 32'(ifb.xpos), 974);
      chk("corner_y2", 32'(ifb.ypos), 703);
      chk("corner_bounce2", 32'(ifb.bounce_cnt), 1);
      chk("edge_x2", 32'(ifc.xpos), 974);
      chk("edge_y2", 32'(ifc.ypos), 102);
      chk("edge_bounce2", 32'(ifc.bounce_cnt), 1);
      chk("main_bounce", 32'(ifa.bounce_cnt), 0);
      repeat (3) run_frame();
      chk("run5_x", 32'(ifa.xpos), 110);
      chk("run5_y", 32'(ifa.ypos), 105);

      // Stop holds position
      pulse(1'b0, 1'b1);
      chk("stop_run", 32'(ifa.running), 0);
      run_frame();
      chk("stop_x", 32'(ifa.xpos), 110);
      chk("stop_y", 32'(ifa.ypos), 105);

      // Simultaneous start and stop stays idle
      pulse(1'b1, 1'b1);
      chk("both_run", 32'(ifa.running), 0);
      run_frame();
      chk("both_x", 32'(ifa.xpos), 110);

      // Restart resumes from held position and direction
      pulse(1'b1, 1'b0);
      chk("resume_run", 32'(ifa.running), 1);
      run_frame();
      chk("resume_x", 32'(ifa.xpos), 112);
      chk("resume_y", 32'(ifa.ypos), 106);

      // Mid-frame reset, released with blank already high
      ifa.vblnk_in = 1'b0;
      step();
      step();
      ifa.vblnk_in = 1'b1;
      rst          = 1'b1;
      step();
      chk("mrst_x", 32'(ifa.xpos), 100);
      chk("mrst_y", 32'(ifa.ypos), 100);
      chk("mrst_run", 32'(ifa.running), 0);
      chk("mrst_bounce", 32'(ifb.bounce_cnt), 0);
      chk("mrst_tick", 32'(ifa.frame_tick), 0);
      rst   = 1'b0;
      tick0 = tick_cnt;
      repeat (4) step();
      chk("mrst_no_tick", 32'(tick_cnt - tick0), 0);
      chk("mrst_x_hold", 32'(ifa.xpos), 100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
